hazard_sequencer: RTL

//  Pipeline control sequencer: decides each cycle whether PC, IF/ID and ID/EX advance, stall or flush.

---
 rtl/hazard_sequencer_if.sv | 29 ++
 rtl/hazard_sequencer.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/hazard_sequencer_if.sv
// Hazard-control bundle between the pipeline datapath (master) and the hazard sequencer (slave).
interface hazard_sequencer_if #(
    parameter int REG_AW = 5
);
    logic [REG_AW-1:0] ifid_rs1;
    logic [REG_AW-1:0] ifid_rs2;
    logic              ifid_uses_rs2;
    logic [REG_AW-1:0] idex_rd;
    logic              idex_mem_read;
    logic              br_taken;
    logic              mem_busy;

    logic              pc_write;
    logic              ifid_write;
    logic              ifid_flush;
    logic              idex_bubble;
    logic              idex_flush;
    logic              back_hold;

    modport master (
        output ifid_rs1, ifid_rs2, ifid_uses_rs2, idex_rd, idex_mem_read, br_taken, mem_busy,
        input  pc_write, ifid_write, ifid_flush, idex_bubble, idex_flush, back_hold
    );

    modport slave (
        input  ifid_rs1, ifid_rs2, ifid_uses_rs2, idex_rd, idex_mem_read, br_taken, mem_busy,
        output pc_write, ifid_write, ifid_flush, idex_bubble, idex_flush, back_hold
    );
endinterface

// File: rtl/hazard_sequencer.sv
// Pipeline stall/flush/freeze sequencer with Mealy control outputs.
// Optional performance counters are enabled by defining HAZARD_PERF_CNT_EN.
module hazard_sequencer #(
    parameter int FLUSH_CYCLES = 1,
    parameter int REG_AW       = 5
) (
    input  logic                clk,
    input  logic                rst,
    hazard_sequencer_if.slave   hz
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0]         stall_cnt,
    output logic [31:0]         flush_cnt,
    output logic [31:0]         freeze_cnt
`endif
);

    typedef enum logic [1:0] {RUN, FLUSH, FREEZE} state_t;

    localparam logic [2:0] CNT_INIT = 3'(FLUSH_CYCLES - 1);

    state_t            state_q, state_d;
    state_t            ret_q, ret_d;
    state_t            eff_state;
    logic [2:0]        cnt_q, cnt_d;
    logic [REG_AW-1:0] rd, rs1, rs2;
    logic              lu;

    logic pc_write, ifid_write, ifid_flush, idex_bubble, idex_flush, back_hold;

    assign rd  = hz.idex_rd;
    assign rs1 = hz.ifid_rs1;
    assign rs2 = hz.ifid_rs2;

    // x0 is hard-wired zero, so a load targeting it can never create a dependency.
    assign lu = hz.idex_mem_read && (rd != '0) &&
                ((rd == rs1) || (hz.ifid_uses_rs2 && (rd == rs2)));

    // The cycle that leaves FREEZE behaves exactly like the state being returned to.
    assign eff_state = (state_q == FREEZE && !hz.mem_busy) ? ret_q : state_q;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            ret_q   <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ret_q   <= ret_d;
            cnt_q   <= cnt_d;
        end
    end

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        ret_d   = ret_q;
        cnt_d   = cnt_q;
        case (eff_state)
            RUN: begin
                state_d = RUN;
                if (hz.mem_busy) begin
                    state_d = FREEZE;
                    ret_d   = RUN;
                end else if (hz.br_taken) begin
                    state_d = FLUSH;
                    cnt_d   = CNT_INIT;
                end
            end
            FLUSH: begin
                if (hz.mem_busy) begin
                    state_d = FREEZE;
                    ret_d   = FLUSH;
                end else if (cnt_q == 3'd0) begin
                    state_d = RUN;
                end else begin
                    state_d = FLUSH;
                    cnt_d   = cnt_q - 3'd1;
                end
            end
            FREEZE:  state_d = FREEZE;
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        idex_flush  = 1'b0;
        back_hold   = 1'b0;
        if (rst) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else begin
            case (eff_state)
                RUN: begin
                    if (hz.mem_busy) begin
                        back_hold = 1'b1;
                    end else if (hz.br_taken) begin
                        pc_write   = 1'b1;
                        ifid_write = 1'b1;
                        ifid_flush = 1'b1;
                        idex_flush = 1'b1;
                    end else if (lu) begin
                        idex_bubble = 1'b1;
                    end else begin
                        pc_write   = 1'b1;
                        ifid_write = 1'b1;
                    end
                end
                FLUSH: begin
                    if (hz.mem_busy) begin
                        back_hold = 1'b1;
                    end else begin
                        pc_write   = 1'b1;
                        ifid_write = 1'b1;
                        ifid_flush = 1'b1;
                        idex_flush = 1'b1;
                    end
                end
                default: back_hold = 1'b1;
            endcase
        end
    end

    assign hz.pc_write    = pc_write;
    assign hz.ifid_write  = ifid_write;
    assign hz.ifid_flush  = ifid_flush;
    assign hz.idex_bubble = idex_bubble;
    assign hz.idex_flush  = idex_flush;
    assign hz.back_hold   = back_hold;

`ifdef HAZARD_PERF_CNT_EN
    // back_hold is high exactly on FREEZE cycles and on the cycles that enter FREEZE.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt  <= '0;
            flush_cnt  <= '0;
            freeze_cnt <= '0;
        end else begin
            if (idex_bubble && stall_cnt != '1) stall_cnt  <= stall_cnt + 32'd1;
            if (idex_flush  && flush_cnt != '1) flush_cnt  <= flush_cnt + 32'd1;
            if (back_hold  && freeze_cnt != '1) freeze_cnt <= freeze_cnt + 32'd1;
        end
    end
`endif

endmodule
